// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU (AND / OR / ADD / SUB), one bit per clock, LSB first.
// A registered carry links consecutive bit slices; start/done handshake to the controller.
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       Operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_SUB} op_t;

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic bb;
    logic bit_r;
    logic ncarry;

    // One-bit ALU slice fed from bit 0 of the operand shift registers
    always_comb begin
        bb     = sb[0] ^ (op == OP_SUB);
        bit_r  = 1'b0;
        ncarry = 1'b0;
        case (op)
            OP_AND: bit_r = sa[0] & bb;
            OP_OR:  bit_r = sa[0] | bb;
            default: begin
                bit_r  = sa[0] ^ bb ^ carry;
                ncarry = (sa[0] & bb) | (sa[0] & carry) | (bb & carry);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_AND;
            sa       <= '0;
            sb       <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            CarryOut <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        op    <= op_t'(Operation);
                        cnt   <= '0;
                        carry <= (Operation == 2'd3);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    Result <= {bit_r, Result[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cnt    <= cnt + CW'(1);
                    carry  <= ncarry;
                    if (cnt == CW'(WIDTH - 1)) begin
                        CarryOut <= ncarry;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed plan vectors plus randomized ops
// against an arithmetic reference model.
module tb_serial_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   Operation;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         CarryOut;

    int checks = 0;
    int passed = 0;

    serial_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .Operation(Operation),
        .busy(busy),
        .done(done),
        .Result(Result),
        .CarryOut(CarryOut)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, {carry, result}
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [1:0] opc);
        logic [W:0] r;
        case (opc)
            2'd0: r = {1'b0, x & y};
            2'd1: r = {1'b0, x | y};
            2'd2: r = {1'b0, x} + {1'b0, y};
            default: begin
                r = {1'b0, x - y};
                r[W] = (x >= y);
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait (bounded) for done; inputs scrambled after acceptance
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] opc,
                         output int cycles, output int busy_cnt);
        start = 1'b1; a = x; b = y; Operation = opc;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); Operation = 2'($urandom);
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; Operation = 2'd2;
        tick();
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (Result !== '0) $display("FAIL reset_result got=%h exp=00", Result); else passed++;
        checks++; if (CarryOut !== 1'b0) $display("FAIL reset_carry got=%b exp=0", CarryOut); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{8'h3C, 8'hFF, 8'h07, 8'h05, 8'hA5, 8'hA5};
        logic [W-1:0] vb [6] = '{8'h0F, 8'h01, 8'h05, 8'h07, 8'h0F, 8'h0F};
        logic [1:0]   vo [6] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
        logic [W:0]   exp;
        logic [W-1:0] held;
        int cyc, bc;
        for (int i = 0; i < 6; i++) begin
            exp = model(va[i], vb[i], vo[i]);
            do_op(va[i], vb[i], vo[i], cyc, bc);
            checks++; if (cyc !== W) $display("FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, W); else passed++;
            checks++; if (bc !== W) $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, W); else passed++;
            checks++; if (Result !== exp[W-1:0]) $display("FAIL dir%0d_result got=%h exp=%h", i, Result, exp[W-1:0]); else passed++;
            checks++; if (CarryOut !== exp[W]) $display("FAIL dir%0d_carry got=%b exp=%b", i, CarryOut, exp[W]); else passed++;
            held = exp[W-1:0];
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL dir%0d_after got=%b%b exp=00", i, busy, done); else passed++;
            checks++; if (Result !== held) $display("FAIL dir%0d_held got=%h exp=%h", i, Result, held); else passed++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [1:0]   opc;
        logic [W:0]   exp;
        int cyc, bc;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom); y = W'($urandom); opc = 2'($urandom_range(3, 0));
            exp = model(x, y, opc);
            do_op(x, y, opc, cyc, bc);
            checks++;
            if (cyc !== W || Result !== exp[W-1:0] || CarryOut !== exp[W])
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                         i, opc, x, y, Result, CarryOut, cyc, exp[W-1:0], exp[W], W);
            else passed++;
            if ($urandom_range(1, 0) == 1) tick();
        end
    endtask

    task automatic test_start_ignored();
        int cyc = 0;
        start = 1'b1; a = 8'h10; b = 8'h20; Operation = 2'd2;
        tick();
        start = 1'b0;
        while (!done && cyc < 40) begin
            if (cyc == 2) begin
                start = 1'b1; a = 8'h77; b = 8'h99; Operation = 2'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        checks++; if (cyc !== W) $display("FAIL ignore_latency got=%0d exp=%0d", cyc, W); else passed++;
        checks++; if (Result !== 8'h30) $display("FAIL ignore_result got=%h exp=30", Result); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL ignore_no_restart got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp;
        int cyc, bc;
        exp = model(8'h01, 8'h80, 2'd1);
        do_op(8'h10, 8'h20, 2'd2, cyc, bc);
        checks++; if (done !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", done); else passed++;
        do_op(8'h01, 8'h80, 2'd1, cyc, bc);
        checks++; if (cyc + 1 !== W + 1) $display("FAIL b2b_spacing got=%0d exp=%0d", cyc + 1, W + 1); else passed++;
        checks++; if (Result !== exp[W-1:0]) $display("FAIL b2b_result got=%h exp=%h", Result, exp[W-1:0]); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W:0] exp;
        int cyc, bc;
        int seen = 0;
        start = 1'b1; a = 8'hFF; b = 8'hFF; Operation = 2'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else passed++;
        checks++; if (Result !== '0) $display("FAIL rstmid_result got=%h exp=00", Result); else passed++;
        checks++; if (CarryOut !== 1'b0) $display("FAIL rstmid_carry got=%b exp=0", CarryOut); else passed++;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++; if (seen !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", seen); else passed++;
        exp = model(8'h01, 8'h01, 2'd2);
        do_op(8'h01, 8'h01, 2'd2, cyc, bc);
        checks++; if (Result !== exp[W-1:0] || cyc !== W) $display("FAIL rstmid_after got=%h lat=%0d exp=%h lat=%0d", Result, cyc, exp[W-1:0], W); else passed++;
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; a = '0; b = '0; Operation = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
